// File: rtl/frac_pkg.sv
// Shared defaults and reader state encoding for the fractional-search block feeder.
package frac_pkg;

  localparam int unsigned DEF_HEIGHT = 8;
  localparam int unsigned DEF_PIX_W  = 64;
  localparam int unsigned DEF_GAP    = 1;

  // Counter widths for the default geometry; instances with other HEIGHTs derive their own.
  localparam int unsigned CNT_W = $clog2(2 * DEF_HEIGHT);
  localparam int unsigned ROW_W = $clog2(DEF_HEIGHT);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StGapWait
  } rd_state_e;

endpackage

// File: rtl/frac_row_bank.sv
// One block of storage: ref rows at addresses 0..HEIGHT-1, filter rows at HEIGHT..2*HEIGHT-1.
module frac_row_bank #(
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned PIX_W  = 64
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(2*HEIGHT)-1:0]   wr_addr,
  input  logic [PIX_W-1:0]              wr_data,
  input  logic [$clog2(HEIGHT)-1:0]     rd_row,
  output logic [PIX_W-1:0]              rd_ref,
  output logic [PIX_W-1:0]              rd_filter
);

  localparam int unsigned CntW = $clog2(2 * HEIGHT);

  logic [PIX_W-1:0] mem [2*HEIGHT];
  logic [CntW-1:0]  filt_addr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign filt_addr = CntW'(rd_row) + CntW'(HEIGHT);
  assign rd_ref    = mem[CntW'(rd_row)];
  assign rd_filter = mem[filt_addr];

endmodule

// File: rtl/frac_block_feeder.sv
// Ping-pong block buffer feeding the QPEL search: loads 2*HEIGHT words, replays HEIGHT row pairs.
module frac_block_feeder
  import frac_pkg::*;
#(
  parameter int unsigned HEIGHT = DEF_HEIGHT,  // must be >= 2
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned GAP    = DEF_GAP      // must be >= 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_data,
  output logic [PIX_W-1:0] ref_pix,
  output logic [PIX_W-1:0] filter_pix,
  output logic             input_ready,
  output logic             blk_done
);

  localparam int unsigned CntW = $clog2(2 * HEIGHT);
  localparam int unsigned RowW = $clog2(HEIGHT);
  localparam int unsigned GapW = $clog2(GAP + 1);

  localparam logic [CntW-1:0] LastWord = CntW'(2 * HEIGHT - 1);
  localparam logic [RowW-1:0] LastRow  = RowW'(HEIGHT - 1);
  localparam logic [GapW-1:0] GapLoad  = GapW'(GAP);

  logic [1:0]      full_q;
  logic            wr_bank_q;
  logic            rd_bank_q;
  logic [CntW-1:0] cnt_q;
  rd_state_e       state_q;
  logic [RowW-1:0] row_q;
  logic [GapW-1:0] gap_q;

  logic            accept;
  logic            store;
  logic            blk_last;
  logic            start;
  logic            emit;
  logic [CntW-1:0] wr_addr;
  logic [1:0]      bank_we;
  logic [PIX_W-1:0] bank_ref    [2];
  logic [PIX_W-1:0] bank_filter [2];

  assign in_ready = !full_q[wr_bank_q] && !reset;
  assign accept   = in_valid && in_ready;
  // Words arriving with the counter at 0 and no sof are accepted but dropped.
  assign store    = accept && (in_sof || cnt_q != '0);
  assign wr_addr  = in_sof ? '0 : cnt_q;
  assign blk_last = store && !in_sof && (cnt_q == LastWord);
  assign bank_we  = {store && wr_bank_q, store && !wr_bank_q};

  // row_q sits at 0 outside StStream, so starting emits row 0 in the same cycle.
  assign start = (state_q == StIdle) && full_q[rd_bank_q] && (gap_q == '0);
  assign emit  = start || (state_q == StStream);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frac_row_bank #(
      .HEIGHT (HEIGHT),
      .PIX_W  (PIX_W)
    ) u_bank (
      .clk       (clk),
      .wr_en     (bank_we[b]),
      .wr_addr   (wr_addr),
      .wr_data   (in_data),
      .rd_row    (row_q),
      .rd_ref    (bank_ref[b]),
      .rd_filter (bank_filter[b])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
    end else if (accept) begin
      if (in_sof) begin
        cnt_q <= CntW'(1);
      end else if (blk_last) begin
        cnt_q     <= '0;
        wr_bank_q <= !wr_bank_q;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      gap_q       <= GapLoad;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      ref_pix     <= '0;
      filter_pix  <= '0;
      input_ready <= 1'b0;
      blk_done    <= 1'b0;
    end else begin
      input_ready <= emit;
      blk_done    <= emit && (row_q == LastRow);
      // Writer and reader never touch the same bank's flag in one cycle.
      if (blk_last) begin
        full_q[wr_bank_q] <= 1'b1;
      end
      if (emit) begin
        ref_pix    <= bank_ref[rd_bank_q];
        filter_pix <= bank_filter[rd_bank_q];
      end
      unique case (state_q)
        StIdle: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end
          if (start) begin
            row_q   <= row_q + 1'b1;
            state_q <= StStream;
          end
        end
        StStream: begin
          if (row_q == LastRow) begin
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= !rd_bank_q;
            row_q             <= '0;
            gap_q             <= GapLoad;
            state_q           <= StGapWait;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        StGapWait: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q == GapW'(1)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
